// File: rtl/lut5_cfg_ctrl.sv
// Runtime-programmable LUT5: 32-bit truth table loaded byte-serially into a shadow
// register, committed atomically, evaluated with 1-cycle latency and streamable by a sweep.
module lut5_cfg_ctrl #(
  parameter logic [31:0] DEFAULT_TABLE = 32'h7BE64D5E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic       cfg_abort,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  output logic       cfg_done,
  input  logic       eval_valid,
  input  logic [4:0] A,
  output logic       Y,
  output logic       y_valid,
  input  logic       sweep_start,
  output logic       sweep_valid,
  output logic [4:0] sweep_addr,
  output logic       sweep_y,
  output logic       sweep_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_SWEEP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] table_q, table_d;
  logic [31:0] shadow_q, shadow_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [4:0]  sweep_addr_q, sweep_addr_d;
  logic        y_q, y_d;
  logic        y_valid_q, y_valid_d;
  logic        sweep_done_q, sweep_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      table_q      <= DEFAULT_TABLE;
      shadow_q     <= '0;
      byte_cnt_q   <= '0;
      sweep_addr_q <= '0;
      y_q          <= 1'b0;
      y_valid_q    <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      shadow_q     <= shadow_d;
      byte_cnt_q   <= byte_cnt_d;
      sweep_addr_q <= sweep_addr_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    shadow_d     = shadow_q;
    byte_cnt_d   = byte_cnt_q;
    sweep_addr_d = sweep_addr_q;
    y_d          = y_q;
    y_valid_d    = 1'b0;
    sweep_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
        end else if (sweep_start) begin
          state_d      = S_SWEEP;
          sweep_addr_d = '0;
        end
      end
      S_LOAD: begin
        // Abort wins over a byte presented in the same cycle.
        if (cfg_abort) begin
          state_d = S_IDLE;
        end else if (cfg_valid) begin
          shadow_d[{byte_cnt_q, 3'b000} +: 8] = cfg_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        table_d = shadow_q;
        state_d = S_IDLE;
      end
      S_SWEEP: begin
        sweep_addr_d = sweep_addr_q + 5'd1;
        if (sweep_addr_q == 5'd31) begin
          state_d      = S_IDLE;
          sweep_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reads table_q, so a request in the COMMIT cycle still sees the old table.
    if (eval_valid && (state_q != S_SWEEP)) begin
      y_d       = table_q[A];
      y_valid_d = 1'b1;
    end
  end

  assign cfg_ready   = (state_q == S_LOAD);
  assign cfg_done    = (state_q == S_COMMIT);
  assign sweep_valid = (state_q == S_SWEEP);
  assign sweep_y     = sweep_valid & table_q[sweep_addr_q];
  assign sweep_addr  = sweep_addr_q;
  assign sweep_done  = sweep_done_q;
  assign busy        = (state_q != S_IDLE);
  assign Y           = y_q;
  assign y_valid     = y_valid_q;

endmodule
